lfsr_prng_fifo: RTL

- Parametrised successor to the fixed 64-bit PRNG peripheral.
- Galois LFSR of configurable width with a software-programmable tap polynomial, enable and mode control, and a harvest FIFO of 32-bit samples.
- Sits on the IO peripheral bus and uses the same single-cycle registered read/write handshake as the other IO blocks.
- Software pops random words from a SAMPLE register and polls STATUS for fill level, lockup and underflow.

---
 rtl/lfsr_prng_fifo.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/lfsr_prng_fifo.sv
// Galois LFSR random number source with a programmable tap mask and a FIFO
// of harvested 32-bit samples, exposed through the IO-bus register handshake.
module lfsr_prng_fifo #(
  parameter int               WIDTH  = 64,
  parameter int               DEPTH  = 8,
  parameter logic [255:0]     SEED   = 256'h1,
  parameter logic [255:0]     TAPS   = 256'hD800_0000_0000_0000,
  localparam int              ADDR_W = $clog2(2*(WIDTH/32)+3)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              write_i,
  input  logic [31:0]       write_data_i,
  input  logic [ADDR_W-1:0] write_address_i,
  output logic              write_done_o,
  input  logic              read_i,
  input  logic [ADDR_W-1:0] read_address_i,
  output logic              read_done_o,
  output logic [31:0]       read_data_o
);

  localparam int WORDS = WIDTH / 32;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(2*WORDS);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2*WORDS + 1);
  localparam logic [ADDR_W-1:0] A_SAMPLE = ADDR_W'(2*WORDS + 2);

  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic             en_q, en_d;
  logic             mode_q, mode_d;
  logic [4:0]       hcnt_q, hcnt_d;
  logic             underflow_q, underflow_d;
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             read_done_q, write_done_q;

  logic full, empty, lockup;
  logic wr_state_taps, wr_ctrl, flush;
  logic rd_sample, rd_status, pop, uf_set;
  logic step, push, push_ok;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign lockup = (state_q == '0);

  assign wr_state_taps = write_i && (write_address_i < ADDR_W'(2*WORDS));
  assign wr_ctrl       = write_i && (write_address_i == A_CTRL);
  assign flush         = wr_ctrl && write_data_i[2];

  assign rd_sample = read_i && (read_address_i == A_SAMPLE);
  assign rd_status = read_i && (read_address_i == A_STATUS);
  assign pop       = rd_sample && !empty;
  assign uf_set    = rd_sample && empty;

  // A software write to STATE/TAPS pre-empts the shift; on-demand mode stalls while full
  assign step    = en_q && !wr_state_taps && (!mode_q || !full || pop);
  assign push    = step && (hcnt_q == 5'd31) && !flush;
  assign push_ok = push && (!full || pop);

  // LFSR advance and register-file writes to STATE / TAPS / CTRL
  always_comb begin
    state_d = state_q;
    taps_d  = taps_q;
    en_d    = en_q;
    mode_d  = mode_q;
    if (step) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? taps_q : '0);
    end
    for (int k = 0; k < WORDS; k++) begin
      if (write_i && write_address_i == ADDR_W'(k)) begin
        state_d[32*k +: 32] = write_data_i;
      end
      if (write_i && write_address_i == ADDR_W'(WORDS + k)) begin
        taps_d[32*k +: 32] = write_data_i;
      end
    end
    if (wr_ctrl) begin
      en_d   = write_data_i[0];
      mode_d = write_data_i[1];
    end
  end

  // Harvest counter, FIFO bookkeeping and sticky underflow
  always_comb begin
    hcnt_d      = hcnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    if (wr_state_taps || flush) begin
      hcnt_d = '0;
    end else if (step) begin
      hcnt_d = hcnt_q + 5'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    if (rd_status) begin
      underflow_d = 1'b0;
    end
    if (uf_set) begin
      underflow_d = 1'b1;
    end
  end

  // Read mux over current (pre-write) register values
  always_comb begin
    read_data_d = read_data_q;
    if (read_i) begin
      read_data_d = '0;
      for (int k = 0; k < WORDS; k++) begin
        if (read_address_i == ADDR_W'(k)) begin
          read_data_d = state_q[32*k +: 32];
        end
        if (read_address_i == ADDR_W'(WORDS + k)) begin
          read_data_d = taps_q[32*k +: 32];
        end
      end
      if (read_address_i == A_CTRL) begin
        read_data_d = {30'b0, mode_q, en_q};
      end
      if (read_address_i == A_STATUS) begin
        read_data_d = {20'b0, underflow_q, lockup, full, empty, 8'(count_q)};
      end
      if (read_address_i == A_SAMPLE && !empty) begin
        read_data_d = mem_q[rd_ptr_q];
      end
    end
  end

  // Control/state registers and bus handshake flops
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= SEED_W;
      taps_q       <= TAPS_W;
      en_q         <= 1'b0;
      mode_q       <= 1'b0;
      hcnt_q       <= '0;
      underflow_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      read_data_q  <= '0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      taps_q       <= taps_d;
      en_q         <= en_d;
      mode_q       <= mode_d;
      hcnt_q       <= hcnt_d;
      underflow_q  <= underflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      read_data_q  <= read_data_d;
      read_done_q  <= read_i;
      write_done_q <= write_i;
    end
  end

  // Sample storage; written with the post-step low word on an accepted push
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= state_d[31:0];
    end
  end

  assign read_data_o  = read_data_q;
  assign read_done_o  = read_done_q;
  assign write_done_o = write_done_q;

endmodule
